// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver for the host command path.
//
// Recovers one byte per frame from the asynchronous serial line and presents it
// with a one-cycle strobe. A stop bit received as 0 raises a one-cycle framing
// error instead. The receiver then waits for the line to return high, so a line
// held low cannot produce a string of frames.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (8..65535)
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   rx           serial line input, idle high
//   byte_out     last good byte, held until the next good byte
//   byte_ready   one-cycle pulse when byte_out is updated
//   frame_error  one-cycle pulse when the stop bit is received as 0
//   busy         high while a frame is in progress, through its strobe cycle
//
// Build option:
//   UART_RX_MAJORITY_EN  take a 2-of-3 vote at counts c-1, c and c+1 around each
//                        nominal sample point c. Every decision, and therefore
//                        every strobe, lands one cycle later than in the
//                        single-sample build.

module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_ready,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned DecLag = 1;
`else
  localparam int unsigned DecLag = 0;
`endif
  // Counter value at which each decision is taken.
  localparam logic [15:0] StartDec   = 16'(HalfBit - 1 + DecLag);
  localparam logic [15:0] BitDec     = 16'(CLKS_PER_BIT - 1 + DecLag);
  // A late decision has already consumed one cycle of the next bit period.
  localparam logic [15:0] CntRestart = 16'(DecLag);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  logic [1:0]  r_sync;
  logic        w_rx_s;
  state_e      r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [2:0]  r_idx, w_idx_next;
  logic [7:0]  r_shift, w_shift_next;
  logic [7:0]  r_byte, w_byte_next;
  logic        r_ready, w_ready_next;
  logic        r_ferr, w_ferr_next;
  logic [15:0] w_dec;
  logic        w_at_dec;
  logic        w_bit;

  // Two-flop synchronizer. It resets to the idle level so that reset release
  // cannot look like a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx_s   = r_sync[1];
  assign w_dec    = (r_state == StStart) ? StartDec : BitDec;
  assign w_at_dec = (r_cnt == w_dec);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_samp;

  // Holds the two samples taken just before the decision count. The third
  // sample is the live rx_s value in the decision cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_samp <= 2'b11;
    end else begin
      if (r_cnt == w_dec - 16'd2) r_samp[0] <= w_rx_s;
      if (r_cnt == w_dec - 16'd1) r_samp[1] <= w_rx_s;
    end
  end

  assign w_bit = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_byte  <= w_byte_next;
      r_ready <= w_ready_next;
      r_ferr  <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 16'd1;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_byte_next  = r_byte;
    w_ready_next = 1'b0;
    w_ferr_next  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (!w_rx_s) begin
          w_state_next = StStart;
        end
      end

      StStart: begin
        if (w_at_dec) begin
          if (w_bit) begin
            // Too short to be a start bit.
            w_state_next = StIdle;
          end else begin
            w_state_next = StData;
            w_idx_next   = '0;
            w_cnt_next   = CntRestart;
          end
        end
      end

      StData: begin
        if (w_at_dec) begin
          w_shift_next[r_idx] = w_bit;
          w_cnt_next          = CntRestart;
          if (r_idx == 3'd7) begin
            w_state_next = StStop;
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end

      StStop: begin
        if (w_at_dec) begin
          // Leaving at mid-stop-bit lets an immediately following start bit
          // be caught.
          if (w_bit) begin
            w_byte_next  = r_shift;
            w_ready_next = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = StBreak;
          end
        end
      end

      StBreak: begin
        w_cnt_next = '0;
        if (w_rx_s) begin
          w_state_next = StIdle;
        end
      end

      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign byte_out    = r_byte;
  assign byte_ready  = r_ready;
  assign frame_error = r_ferr;
  // The strobe cycle is already in IDLE, but it still counts as busy.
  assign busy        = (r_state != StIdle) || r_ready;

endmodule
